// File: rtl/dshot_timing_pkg.sv
// Rate constants for the DShot/UART converter, expressed as integer/fraction
// divisor pairs at 16 MHz (mean period = div_int + div_frac/256 cycles).
package dshot_timing_pkg;

  typedef struct packed {
    logic [15:0] div_int;
    logic [7:0]  div_frac;
  } rate_t;

  localparam rate_t DSHOT1200  = '{div_int: 16'd13,  div_frac: 8'd85};
  localparam rate_t DSHOT600   = '{div_int: 16'd26,  div_frac: 8'd171};
  localparam rate_t DSHOT300   = '{div_int: 16'd53,  div_frac: 8'd85};
  localparam rate_t DSHOT150   = '{div_int: 16'd106, div_frac: 8'd171};
  localparam rate_t UART115200 = '{div_int: 16'd138, div_frac: 8'd228};

endpackage

// File: rtl/frac_phase_acc.sv
// Fractional phase accumulator: adds the active fraction at every period wrap
// and flags the next period as one cycle longer on carry-out.
module frac_phase_acc #(
  parameter int FRAC_W = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              ext
);

  logic [FRAC_W-1:0] acc;

  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (step) begin
      {ext, acc} <= {1'b0, acc} + {1'b0, frac};
    end
  end

endmodule

// File: rtl/baud_tick_gen_frac.sv
// Runtime-programmable fractional bit-timing generator: period tick plus
// half/quarter strobes and levels for the DShot encoder and UART shifter.
module baud_tick_gen_frac
  import dshot_timing_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_DIV  = int'(DSHOT150.div_int),
  parameter int DEFAULT_FRAC = int'(DSHOT150.div_frac),
  parameter int MIN_DIV      = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              half_tick,
  output logic              quarter_tick,
  output logic              half_level,
  output logic              quarter_level,
  output logic              update_pending
);

  localparam int CW = DIV_W + 1;
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     period, half, quarter, three_q;
  logic [DIV_W-1:0]  n_q, n_p, div_clamped;
  logic [FRAC_W-1:0] f_q, f_p;
  logic              pend, ext;
  logic              wrap, apply_load, apply_pend;

  assign period      = {1'b0, n_q} + CW'(ext);
  assign half        = period >> 1;
  assign quarter     = period >> 2;
  assign three_q     = half + quarter;
  assign wrap        = enable && (cnt == period - 1'b1);
  assign div_clamped = (div_int < MIN_DIV_V) ? MIN_DIV_V : div_int;

  // A load landing on the wrap itself bypasses the pending registers.
  assign apply_load  = load && wrap;
  assign apply_pend  = pend && (wrap || !enable) && !apply_load;

  assign update_pending = pend;

  frac_phase_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (!enable || apply_load || apply_pend),
    .step   (wrap),
    .frac   (f_q),
    .ext    (ext)
  );

  // NOTE: outputs are registered decodes of the pre-edge count, so every input
  // (enable included) reaches them only through a flop.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt           <= '0;
      n_q           <= DIV_W'(DEFAULT_DIV);
      f_q           <= FRAC_W'(DEFAULT_FRAC);
      n_p           <= DIV_W'(DEFAULT_DIV);
      f_p           <= FRAC_W'(DEFAULT_FRAC);
      pend          <= 1'b0;
      tick          <= 1'b0;
      half_tick     <= 1'b0;
      quarter_tick  <= 1'b0;
      half_level    <= 1'b0;
      quarter_level <= 1'b0;
    end else begin
      cnt <= (wrap || !enable) ? '0 : cnt + 1'b1;

      if (apply_load) begin
        n_q <= div_clamped;
        f_q <= div_frac;
      end else if (apply_pend) begin
        n_q <= n_p;
        f_q <= f_p;
      end

      if (load && !wrap) begin
        n_p  <= div_clamped;
        f_p  <= div_frac;
        pend <= 1'b1;
      end else if (apply_load || apply_pend) begin
        pend <= 1'b0;
      end

      tick          <= wrap;
      half_tick     <= enable && (cnt == half);
      quarter_tick  <= enable && (cnt == quarter || cnt == half || cnt == three_q);
      half_level    <= enable && (cnt >= half);
      quarter_level <= enable && ((cnt >= quarter && cnt < half) || cnt >= three_q);
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed self-checking bench for baud_tick_gen_frac; outputs are sampled on
// the falling edge and reflect the count seen at the preceding rising edge.
module tb_baud_tick_gen_frac;

  logic        clk_in = 1'b0;
  logic        reset, enable, load;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic        tick, half_tick, quarter_tick, half_level, quarter_level, update_pending;

  int n_checks = 0;
  int n_errors = 0;

  baud_tick_gen_frac dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .div_int        (div_int),
    .div_frac       (div_frac),
    .tick           (tick),
    .half_tick      (half_tick),
    .quarter_tick   (quarter_tick),
    .half_level     (half_level),
    .quarter_level  (quarter_level),
    .update_pending (update_pending)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [5:0] outs();
    return {tick, half_tick, quarter_tick, half_level, quarter_level, update_pending};
  endfunction

  // Count cycles until the next tick; a missing tick shows up as a wrong count.
  task automatic wait_tick(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 300);
    check(tag, n, exp);
  endtask

  task automatic collect(input int len, output logic [7:0] t, output logic [7:0] h,
                         output logic [7:0] q, output logic [7:0] hl, output logic [7:0] ql);
    t = '0; h = '0; q = '0; hl = '0; ql = '0;
    for (int j = 0; j < len; j++) begin
      cyc();
      t[j] = tick; h[j] = half_tick; q[j] = quarter_tick;
      hl[j] = half_level; ql[j] = quarter_level;
    end
  endtask

  initial begin
    logic [7:0] t, h, q, hl, ql;
    int total, n;

    reset = 1'b1; enable = 1'b0; load = 1'b0; div_int = '0; div_frac = '0;
    cyc();
    check("reset_outputs", 32'(outs()), 0);
    enable = 1'b1;
    cyc();
    check("reset_overrides_enable", 32'(outs()), 0);

    // Defaults 106/171: periods 106, 106, 107; 256 periods after the first tick.
    reset = 1'b0;
    wait_tick("default_p1", 106);
    wait_tick("default_p2", 106);
    wait_tick("default_p3", 107);
    total = 213;
    for (int k = 0; k < 254; k++) begin
      n = 0;
      do begin
        cyc();
        n++;
      end while (!tick && n < 300);
      total += n;
    end
    check("default_256_periods", total, 27307);

    // Mid-period load 53/85: pending until the current period's tick.
    cycles(20);
    load = 1'b1; div_int = 16'd53; div_frac = 8'd85;
    cyc();
    load = 1'b0;
    check("pending_after_load", 32'(update_pending), 1);
    n = 0;
    while (n < 200) begin
      cyc();
      n++;
      if (tick) break;
      check("pending_held", 32'(update_pending), 1);
    end
    check("apply_tick_seen", 32'(tick), 1);
    check("pending_cleared", 32'(update_pending), 0);
    wait_tick("dshot300_period", 53);

    // Load 2/0 exactly on the tick cycle: clamped to 4 and applied at once.
    cycles(52);
    load = 1'b1; div_int = 16'd2; div_frac = 8'd0;
    cyc();
    load = 1'b0;
    check("load_at_tick_tick", 32'(tick), 1);
    check("load_at_tick_no_pending", 32'(update_pending), 0);
    collect(4, t, h, q, hl, ql);
    check("p4_tick", 32'(t), 32'h08);
    check("p4_half_tick", 32'(h), 32'h04);
    check("p4_quarter_tick", 32'(q), 32'h0E);
    check("p4_half_level", 32'(hl), 32'h0C);
    check("p4_quarter_level", 32'(ql), 32'h0A);
    wait_tick("p4_period", 4);

    // Idle load 8/0, applied on the next disabled edge, then enable.
    enable = 1'b0;
    cyc();
    check("idle_outputs", 32'(outs()), 0);
    load = 1'b1; div_int = 16'd8; div_frac = 8'd0;
    cyc();
    load = 1'b0;
    check("idle_pending_set", 32'(update_pending), 1);
    cyc();
    check("idle_pending_applied", 32'(update_pending), 0);
    enable = 1'b1;
    wait_tick("p8_first_tick", 8);
    collect(8, t, h, q, hl, ql);
    check("p8_tick", 32'(t), 32'h80);
    check("p8_half_tick", 32'(h), 32'h10);
    check("p8_quarter_tick", 32'(q), 32'h54);
    check("p8_half_level", 32'(hl), 32'hF0);
    check("p8_quarter_level", 32'(ql), 32'hCC);

    // Drop enable for one cycle at cnt = 50 of a 53/85 period.
    enable = 1'b0;
    load = 1'b1; div_int = 16'd53; div_frac = 8'd85;
    cyc();
    load = 1'b0;
    cyc();
    enable = 1'b1;
    cycles(50);
    check("before_drop_no_tick", 32'(tick), 0);
    enable = 1'b0;
    cyc();
    check("drop_outputs", 32'(outs()), 0);
    enable = 1'b1;
    wait_tick("realign_p1", 53);
    wait_tick("realign_p2", 53);

    // Reset mid-period with a pending load: defaults return, pending discarded.
    cycles(30);
    load = 1'b1; div_int = 16'd13; div_frac = 8'd85;
    cyc();
    load = 1'b0;
    check("pre_reset_pending", 32'(update_pending), 1);
    reset = 1'b1;
    cyc();
    check("mid_reset_outputs", 32'(outs()), 0);
    reset = 1'b0;
    wait_tick("post_reset_p1", 106);
    check("post_reset_no_pending", 32'(update_pending), 0);
    wait_tick("post_reset_p2", 106);
    wait_tick("post_reset_p3", 107);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_frac.md
# baud_tick_gen_frac

Runtime-programmable bit-timing generator for the DShot/UART converter datapath. It is the parametrised successor to the fixed-rate 16 MHz baud divisor. The divisor is loaded at run time as an integer plus a fraction, so DShot150/300/600/1200 and UART rates track their nominal frequency exactly on average. It emits a single-cycle period tick, half and quarter strobes, and half/quarter square-wave levels for the DShot encoder and the UART shifter.

## Interface
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 8: width of the fractional divisor and of the phase accumulator.
- `DEFAULT_DIV`, 106: integer divisor active after reset (DShot150 at 16 MHz).
- `DEFAULT_FRAC`, 171: fractional divisor active after reset.
- `MIN_DIV`, 4: smallest integer divisor accepted; smaller loads are clamped up to this value.

Ports:
- `clk_in`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run; low holds the generator idle and phase-aligned.
- `load`, in, 1: one-cycle strobe that captures `div_int` and `div_frac`.
- `div_int`, in, DIV_W: integer part N of the period.
- `div_frac`, in, FRAC_W: fractional part F; mean period is N + F/2^FRAC_W cycles.
- `tick`, out, 1: one-cycle pulse in the last cycle of each period.
- `half_tick`, out, 1: one-cycle pulse at the period midpoint.
- `quarter_tick`, out, 1: one-cycle pulse at the 1/4, 2/4 and 3/4 points.
- `half_level`, out, 1: high for the second half of the period.
- `quarter_level`, out, 1: high during the 2nd and 4th quarters.
- `update_pending`, out, 1: a loaded divisor is waiting for a period boundary.

## Operation
- State:
  - Period counter `cnt` (DIV_W+1 bits).
  - Active divisor `n_q`/`f_q`, pending divisor `n_p`/`f_p` and `pend` flag.
  - Accumulator `acc` (FRAC_W bits) and extension flag `ext`.
- Derived values:
  - Current period P = `n_q` + `ext`.
  - H = P>>1 and Q = P>>2 (truncating).
- Counting: with `enable` high, `cnt` increments each cycle. When `cnt` = P-1 it wraps to 0.
- Fraction update at each wrap:
  - Compute {carry, `acc`} ← `acc` + `f_q`.
  - Set `ext` ← carry.
  - Over any 2^FRAC_W consecutive periods, exactly `f_q` periods are N+1 cycles long.
- Decodes, all gated by `enable` and with no combinational path from any input to any output:
  - `tick` when `cnt` = P-1.
  - `half_tick` when `cnt` = H.
  - `quarter_tick` when `cnt` ∈ {Q, H, H+Q}.
  - `half_level` when `cnt` ≥ H.
  - `quarter_level` when (Q ≤ `cnt` < H) or `cnt` ≥ H+Q.
- Load:
  - `load` captures max(`div_int`, MIN_DIV) and `div_frac` into the pending registers and sets `pend`.
  - A later `load` before the pending value is applied overwrites it.
- Apply: the pending divisor moves to the active registers, `acc` and `ext` are cleared, and `pend` is cleared. This happens:
  - on the next wrap while enabled, or
  - on the next edge while `enable` is low.
- `load` in the same cycle as `tick`: the new value is applied directly at that wrap, so the next period uses it. `update_pending` stays 0.
- `enable` low:
  - `cnt`, `acc` and `ext` are held at 0.
  - All timing outputs are 0.
  - This is the phase-realignment mechanism.
- Reset:
  - `cnt`, `acc`, `ext` and `pend` are cleared.
  - `n_q`/`f_q` are set to DEFAULT_DIV/DEFAULT_FRAC.
  - Reset overrides `load` and `enable`, and abandons any period in progress.

## Timing
- From the first edge at which `reset` is sampled high, every output is 0.
- After `enable` rises, the first `tick` appears in the P-th consecutive enabled cycle, counting the first enabled cycle as cycle 1. The first period always has `ext` = 0.
- After that, one `tick` per period, with no gap cycles.
- `load` → `update_pending` high in the next cycle. It clears in the cycle after the applying wrap.
- Minimum P is 4, which guarantees Q, H and H+Q are distinct and nonzero.

## Structure
- Shared package `dshot_timing_pkg` holds the rate constants at 16 MHz as integer/fraction pairs:
  - DSHOT1200: 13/85
  - DSHOT600: 26/171
  - DSHOT300: 53/85
  - DSHOT150: 106/171
  - UART115200: 138/228
- One sub-module, `frac_phase_acc`: holds `acc`/`ext` and performs the wrap-time add and carry. It is cleared on enable-low, reset or divisor apply.

## Test plan
- Reset, then `enable` high with defaults (106/171) → tick periods 106, 106, 107, …; 256 periods total exactly 27307 cycles.
- `load` 8/0 while idle, then enable → `tick` every 8 cycles, first tick in cycle 8; `half_tick` at `cnt` 4; `quarter_tick` at `cnt` 2, 4, 6; `half_level` high for `cnt` 4–7.
- `load` 53/85 mid-period while running 106/171 → `update_pending` = 1 until the current period's `tick`; the following period is 53 cycles.
- `load` 2/0 → clamped; tick period 4 with quarter strobes at `cnt` 1, 2, 3.
- Drop `enable` for 1 cycle at `cnt` = 50 → outputs 0 that cycle; the next tick arrives P cycles after re-enable, with `acc` restarted at 0.
- Assert `reset` mid-period with a pending load → outputs 0 next cycle, pending discarded, period reverts to 106/171.
